if_id_queue: RTL and testbench

IF_ID_QUEUE -- requirements
Module: if_id_queue

---
 rtl/pipeline_pkg.sv | 42 ++++
 rtl/if_id_decode.sv | 38 +++
 rtl/if_id_queue.sv | 128 ++++++++++++
 tb/tb_if_id_queue.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Pipeline-wide instruction encoding constants and the decoded-field bundle
// shared by the IF/ID queue and other decode-aware stages.
package pipeline_pkg;

  localparam int INST_W = 32;
  localparam int OPC_W  = 12;
  localparam int REG_W  = 5;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;
  localparam int SH_HI = 10;
  localparam int SH_LO = 6;
  localparam int FN_HI = 5;
  localparam int FN_LO = 0;

  localparam logic [5:0]       R_OP   = 6'h00;
  localparam logic [5:0]       JAL_OP = 6'h03;
  localparam logic [OPC_W-1:0] SLL    = 12'h000;
  localparam logic [OPC_W-1:0] SRL    = 12'h002;
  localparam logic [REG_W-1:0] RA_IDX = 5'd31;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
  } dec_t;

  // R-type instructions are distinguished by funct, so it joins the major opcode.
  function automatic logic [OPC_W-1:0] make_opcode(input logic [INST_W-1:0] inst);
    logic [5:0] op;
    op = inst[OP_HI:OP_LO];
    return {op, (op == R_OP) ? inst[FN_HI:FN_LO] : 6'b0};
  endfunction

endpackage

// File: rtl/if_id_decode.sv
// Combinational field extraction: 12-bit opcode plus source/destination
// register indices for one instruction word.
module if_id_decode
  import pipeline_pkg::*;
(
  input  logic [INST_W-1:0] inst_i,
  output logic [OPC_W-1:0]  opcode_o,
  output logic [REG_W-1:0]  rs1_o,
  output logic [REG_W-1:0]  rs2_o,
  output logic [REG_W-1:0]  rd_o
);

  logic [5:0] op;
  logic       unused_shamt;

  assign op           = inst_i[OP_HI:OP_LO];
  assign opcode_o     = make_opcode(inst_i);
  assign rs2_o        = inst_i[RT_HI:RT_LO];
  assign unused_shamt = ^inst_i[SH_HI:SH_LO];

  // Shifts by immediate read their operand from the rt slot.
  always_comb begin
    rs1_o = inst_i[RS_HI:RS_LO];
    if ((opcode_o == SLL) || (opcode_o == SRL)) begin
      rs1_o = inst_i[RT_HI:RT_LO];
    end
  end

  always_comb begin
    rd_o = inst_i[RT_HI:RT_LO];
    if (op == R_OP) begin
      rd_o = inst_i[RD_HI:RD_LO];
    end else if (op == JAL_OP) begin
      rd_o = RA_IDX;
    end
  end

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: stores fetched instructions with their decode
// computed at push time and presents the head to ID, zeroed when empty.
module if_id_queue
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [XLEN-1:0]              in_pc,
  input  logic [INST_W-1:0]            in_inst,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_pc,
  output logic [INST_W-1:0]            out_inst,
  output logic [OPC_W-1:0]             out_opcode,
  output logic [REG_W-1:0]             out_rs1_ind,
  output logic [REG_W-1:0]             out_rs2_ind,
  output logic [REG_W-1:0]             out_rd_ind,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
    dec_t              dec;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            push;
  logic            pop;
  dec_t            in_dec;
  entry_t          wr_entry;
  entry_t          head;

  if_id_decode u_decode (
    .inst_i   (in_inst),
    .opcode_o (in_dec.opcode),
    .rs1_o    (in_dec.rs1),
    .rs2_o    (in_dec.rs2),
    .rd_o     (in_dec.rd)
  );

  // in_ready ignores a same-cycle pop so there is no out_ready -> in_ready path.
  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  assign wr_entry.pc   = in_pc;
  assign wr_entry.inst = in_inst;
  assign wr_entry.dec  = in_dec;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is left uncleared; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    out_pc      = '0;
    out_inst    = '0;
    out_opcode  = '0;
    out_rs1_ind = '0;
    out_rs2_ind = '0;
    out_rd_ind  = '0;
    if (out_valid) begin
      out_pc      = head.pc;
      out_inst    = head.inst;
      out_opcode  = head.dec.opcode;
      out_rs1_ind = head.dec.rs1;
      out_rs2_ind = head.dec.rs2;
      out_rd_ind  = head.dec.rd;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: stimulus queues expected entries, a
// negedge monitor checks every pop and every bubble.
module tb_if_id_queue;

  typedef struct {
    logic [31:0] inst;
    logic [11:0] opc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] opc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [11:0] out_opcode;
  logic [4:0]  out_rs1_ind;
  logic [4:0]  out_rs2_ind;
  logic [4:0]  out_rd_ind;
  logic [2:0]  count;

  vec_t  vecs [8];
  exp_t  exp_q [$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    pc_seq  = 0;

  if_id_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_inst     (in_inst),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .out_opcode  (out_opcode),
    .out_rs1_ind (out_rs1_ind),
    .out_rs2_ind (out_rs2_ind),
    .out_rd_ind  (out_rd_ind),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; inputs return to idle just after the edge.
  task automatic drive(input bit v, input int idx, input bit ordy, input bit fl, input bit acc);
    exp_t e;
    in_valid  = v;
    in_pc     = 32'h0000_1000 + 32'(pc_seq) * 4;
    in_inst   = vecs[idx].inst;
    out_ready = ordy;
    flush     = fl;
    if (fl) exp_q.delete();
    if (acc) begin
      e.pc   = in_pc;
      e.inst = vecs[idx].inst;
      e.opc  = vecs[idx].opc;
      e.rs1  = vecs[idx].rs1;
      e.rs2  = vecs[idx].rs2;
      e.rd   = vecs[idx].rd;
      exp_q.push_back(e);
    end
    pc_seq++;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_count"}, count, 0);
    check({tag, "_data_zero"},
          |{out_pc, out_inst, out_opcode, out_rs1_ind, out_rs2_ind, out_rd_ind}, 0);
  endtask

  // Monitor: inputs are stable at negedge, so a pop seen here commits at the next posedge.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      if (out_valid === 1'b1 && out_ready === 1'b1 && flush === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL pop_unexpected: actual pc 0x%0h required no entry", out_pc);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", out_pc, e.pc);
          check("pop_inst", out_inst, e.inst);
          check("pop_opcode", out_opcode, e.opc);
          check("pop_rs1", out_rs1_ind, e.rs1);
          check("pop_rs2", out_rs2_ind, e.rs2);
          check("pop_rd", out_rd_ind, e.rd);
        end
      end else if (out_valid === 1'b0) begin
        check("bubble_zero",
              |{out_pc, out_inst, out_opcode, out_rs1_ind, out_rs2_ind, out_rd_ind}, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{32'h0022_1820, 12'h020, 5'd1,  5'd2,  5'd3};
    vecs[1] = '{32'h0005_1100, 12'h000, 5'd5,  5'd5,  5'd2};
    vecs[2] = '{32'h0C00_0010, 12'h0C0, 5'd0,  5'd0,  5'd31};
    vecs[3] = '{32'h0006_20C2, 12'h002, 5'd6,  5'd6,  5'd4};
    vecs[4] = '{32'h8D28_0004, 12'h8C0, 5'd9,  5'd8,  5'd8};
    vecs[5] = '{32'h016C_5022, 12'h022, 5'd11, 5'd12, 5'd10};
    vecs[6] = '{32'h2067_0005, 12'h200, 5'd3,  5'd7,  5'd7};
    vecs[7] = '{32'h1022_0003, 12'h100, 5'd1,  5'd2,  5'd2};

    @(posedge clk);
    #1;
    check_bubble("reset");
    rst = 1'b0;

    // Single push: visible after one edge, decoded fields carried with it.
    drive(1, 0, 0, 0, 1);
    check("add_out_valid", out_valid, 1);
    check("add_count", count, 1);
    check("add_opcode", out_opcode, 12'h020);
    check("add_rs1", out_rs1_ind, 1);
    check("add_rs2", out_rs2_ind, 2);
    check("add_rd", out_rd_ind, 3);
    drive(0, 0, 1, 0, 0);
    check_bubble("add_drained");

    // Pop request on an empty queue does nothing.
    drive(0, 0, 1, 0, 0);
    check("empty_pop_count", count, 0);

    // Fill to DEPTH, then a fifth push must be refused.
    for (int i = 1; i <= 4; i++) drive(1, i, 0, 0, 1);
    check("full_count", count, 4);
    check("full_in_ready", in_ready, 0);
    drive(1, 5, 0, 0, 0);
    check("full_ignore_count", count, 4);
    repeat (4) drive(0, 0, 1, 0, 0);
    check("drain_count", count, 0);

    // Simultaneous push/pop at count 2, then pop with in_valid while full.
    drive(1, 5, 0, 0, 1);
    drive(1, 6, 0, 0, 1);
    check("two_count", count, 2);
    drive(1, 7, 1, 0, 1);
    check("pushpop_count", count, 2);
    drive(1, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 1);
    check("refill_count", count, 4);
    drive(1, 2, 1, 0, 0);
    check("full_pop_count", count, 3);
    check("full_pop_in_ready", in_ready, 1);
    repeat (3) drive(0, 0, 1, 0, 0);
    check("drain2_count", count, 0);

    // Flush at count 3 with in_valid and out_ready high.
    for (int i = 3; i <= 5; i++) drive(1, i, 0, 0, 1);
    check("preflush_count", count, 3);
    drive(1, 6, 1, 1, 0);
    check_bubble("flush");
    drive(1, 7, 0, 0, 1);
    check("postflush_count", count, 1);
    drive(0, 0, 1, 0, 0);

    // Asynchronous reset between edges at count 2.
    drive(1, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 1);
    check("prerst_count", count, 2);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_bubble("async_rst");
    #2;
    rst = 1'b0;
    drive(1, 2, 0, 0, 1);
    check("postrst_count", count, 1);
    drive(0, 0, 1, 0, 0);
    check("postrst_drain", count, 0);

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
